// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's connection to the RAM arbiter.
//   req           level request; address/data_in/write_enable held while high
//   address       request address
//   data_in       write data
//   write_enable  1 = write, 0 = read
//   data_out      registered read data, valid with done and held afterwards
//   done          one-cycle completion pulse
// master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  done;

    modport master (
        output req, address, data_in, write_enable,
        input  data_out, done
    );

    modport slave (
        input  req, address, data_in, write_enable,
        output data_out, done
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported, synchronous-read RAM between two
// requesters (a = SPC700 core, b = DSP voice engine). A winning request is
// captured, drives the RAM for one cycle (ACCESS), and its read data is
// registered into the port's data_out on the following edge (COMPLETE).
//   clock, reset      single clock; asynchronous active-high reset
//   a, b              requester ports (ram_arbiter_if.slave)
//   ram_address       RAM address (last captured value)
//   ram_data_in       RAM write data (last captured value)
//   ram_write_enable  RAM write strobe, high only in ACCESS for a write
//   ram_data_out      RAM read data, valid the cycle after ACCESS
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_arbiter_if.slave          a,
    ram_arbiter_if.slave          b,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t                state, state_next;
    logic                  grant, last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  we_q;
    logic                  a_done_q, b_done_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

    logic finishing_a, finishing_b;
    logic elig_a, elig_b;
    logic win, win_b;

    always_comb begin
        // A port whose done is high, or which is completing this edge, sits
        // out one arbitration so its requester can react to done.
        finishing_a = (state == COMPLETE) && (grant == PORT_A);
        finishing_b = (state == COMPLETE) && (grant == PORT_B);
        elig_a      = a.req && !a_done_q && !finishing_a;
        elig_b      = b.req && !b_done_q && !finishing_b;
        win         = (state != ACCESS) && (elig_a || elig_b);
        if (elig_a && elig_b) begin
            win_b = (FIXED_PRIORITY != 0) ? PORT_A : (last_grant == PORT_A);
        end else begin
            win_b = elig_b;
        end

        state_next = state;
        case (state)
            IDLE:     if (win) state_next = ACCESS;
            ACCESS:   state_next = COMPLETE;
            COMPLETE: state_next = win ? ACCESS : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant      <= PORT_A;
            last_grant <= PORT_B;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            if (state == COMPLETE) begin
                if (grant == PORT_A) begin
                    a_done_q <= 1'b1;
                    if (!we_q) a_rdata_q <= ram_data_out;
                end else begin
                    b_done_q <= 1'b1;
                    if (!we_q) b_rdata_q <= ram_data_out;
                end
            end
            if (win) begin
                addr_q     <= win_b ? b.address      : a.address;
                data_q     <= win_b ? b.data_in      : a.data_in;
                we_q       <= win_b ? b.write_enable : a.write_enable;
                grant      <= win_b;
                last_grant <= win_b;
            end
        end
    end

    // Gating with the state register makes reset drop a pending write at once.
    assign ram_address      = addr_q;
    assign ram_data_in      = data_q;
    assign ram_write_enable = (state == ACCESS) && we_q;

    assign a.done     = a_done_q;
    assign b.done     = b_done_q;
    assign a.data_out = a_rdata_q;
    assign b.data_out = b_rdata_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-ported, synchronous-read 64 KiB audio RAM between two requesters (port A: SPC700 core, port B: DSP voice engine). Each requester runs a level req / pulsed done handshake. The arbiter captures the winning request, drives the RAM for exactly one cycle, and returns the read data one cycle later. It sits between the two masters and the RAM macro, which registers its read data on the same clock edge that performs any write and returns the pre-write contents.

## Interface
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- FIXED_PRIORITY, 0, 0 = round-robin between A and B; 1 = port A always wins ties.
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- a_req, b_req  input  1  level request; address, write data and write enable are held stable while high.
- a_address, b_address  input  ADDR_WIDTH  request address.
- a_data_in, b_data_in  input  DATA_WIDTH  write data.
- a_write_enable, b_write_enable  input  1  1 = write, 0 = read.
- a_data_out, b_data_out  output  DATA_WIDTH  registered read data; valid while the port's done is high and held afterwards.
- a_done, b_done  output  1  registered one-cycle completion pulse.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_data_in  output  DATA_WIDTH  to RAM write data.
- ram_write_enable  output  1  to RAM; high only in ACCESS with a captured write.
- ram_data_out  input  DATA_WIDTH  from RAM; valid the cycle after ACCESS.

## Operation
- States: IDLE, ACCESS, COMPLETE. Registers: captured address, data and write enable; grant (A/B); last_grant; a_done and b_done; a_data_out and b_data_out.
- Eligible(port) = req high, AND the port's done register is 0, AND the port is not the one finishing in COMPLETE this edge.
- Arbitration runs at each edge in IDLE or COMPLETE:
  - Only one port eligible: that port wins.
  - Both eligible, FIXED_PRIORITY=1: A wins.
  - Both eligible, FIXED_PRIORITY=0: the port that is not last_grant wins.
- On a win: capture address, data and write enable; set grant and last_grant; next state ACCESS.
- IDLE: no eligible port -> stay in IDLE.
- ACCESS: ram_address, ram_data_in and ram_write_enable are driven from the captured registers. Always -> COMPLETE.
- COMPLETE, at the leaving edge:
  - Granted port's done <= 1.
  - On a read, granted port's data_out <= ram_data_out.
  - On a write, data_out is unchanged.
  - Then arbitrate: a winner goes directly to ACCESS, otherwise IDLE.
- done clears on the following edge: it is a single-cycle pulse.
- ram_address and ram_data_in hold the last captured values outside ACCESS. ram_write_enable is 0 outside ACCESS.
- Reset values:
  - state IDLE; last_grant = B, so A wins the first tie.
  - All captured registers 0; a_done and b_done 0; a_data_out and b_data_out 0.
  - Consequently ram_address, ram_data_in and ram_write_enable are all 0.
- Reset mid-transaction abandons the transaction. No done is issued. A write in ACCESS at reset assertion is dropped, because ram_write_enable goes to 0 asynchronously.

## Timing
- Request sampled at edge E0 (IDLE). ACCESS runs E0–E1, with the RAM operating at E1. COMPLETE runs E1–E2. done is high E2–E3.
- Latency from sampled req to done visible: 2 cycles.
- Edge E3 ignores that port's req, because its done is 1. This lets a registered requester update address or drop req in response to done.
- A single port with req held high is accepted every 4 cycles (E0, E4, ...).
- Both ports continuously requesting: ACCESS/COMPLETE alternate with no IDLE gap. Grants alternate A, B, A, ... and one access completes every 2 cycles.
- A req arriving while the other port is in ACCESS waits at most 1 cycle to be captured (at the COMPLETE edge).

## Test plan
- Reset, then A writes 0x5A to 0x1234, then A reads 0x1234 -> a_done pulses 2 cycles after each sample; ram_write_enable high for exactly 1 cycle; read returns a_data_out = 0x5A; b_done stays 0.
- A and B both request from IDLE, FIXED_PRIORITY=0 (A reads 0x0010 = 0x11, B reads 0x0020 = 0x22) -> A granted first; a_done then b_done on consecutive COMPLETE edges 2 cycles apart; data 0x11 and 0x22 respectively.
- Both requesting continuously for 8 grants -> order A, B, A, B, ...; no IDLE cycles. Same run with FIXED_PRIORITY=1 and A re-asserting immediately -> B is served only in A's post-done blackout cycles.
- Single port holding req high with incrementing address 0x0000–0x0003 -> accepts exactly every 4 cycles; no duplicate access on the cycle done is high.
- A write of 0x77 to 0x0100 preceded by a read of 0x0100 (old value 0x33) -> read returns 0x33; after the write, a_data_out stays 0x33 (not updated on writes).
- reset asserted mid-cycle during ACCESS of a B write -> ram_write_enable drops to 0 immediately; no b_done; target RAM byte unchanged; state IDLE after release.
